ihex_loader: RTL and testbench

- Streaming Intel HEX parser for the ioctl download path; turns ASCII HEX bytes into byte-lane writes on a program/data RAM port.
- Generalises the fixed inline loader: parametrised address and word width, checksum verification, extended addressing (types 02/04), range checking, done/error status.
- Sits in clk_sys between hps_io ioctl outputs and a dual-port ROM/RAM.

---
 rtl/ihex_pkg.sv | 42 ++++
 rtl/ihex_nibble.sv | 30 +++
 rtl/ihex_loader.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_ihex_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ihex_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ihex_pkg                                                  |
// | Purpose  : Shared types and constants for the Intel HEX loader       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package ihex_pkg;

  // Parser state; ADR covers all four address nibbles
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CNT_H = 4'd1,
    S_CNT_L = 4'd2,
    S_ADR   = 4'd3,
    S_TYP_H = 4'd4,
    S_TYP_L = 4'd5,
    S_DAT_H = 4'd6,
    S_DAT_L = 4'd7,
    S_CK_H  = 4'd8,
    S_CK_L  = 4'd9,
    S_DONE  = 4'd10,
    S_ERR   = 4'd11
  } state_t;

  // Record types
  localparam logic [7:0] REC_DATA = 8'h00;
  localparam logic [7:0] REC_EOF  = 8'h01;
  localparam logic [7:0] REC_ESA  = 8'h02;
  localparam logic [7:0] REC_SSA  = 8'h03;
  localparam logic [7:0] REC_ELA  = 8'h04;
  localparam logic [7:0] REC_SLA  = 8'h05;

  // Sticky error codes
  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_CHAR  = 3'd1;
  localparam logic [2:0] ERR_CKSUM = 3'd2;
  localparam logic [2:0] ERR_RANGE = 3'd3;
  localparam logic [2:0] ERR_TYPE  = 3'd4;
  localparam logic [2:0] ERR_TRUNC = 3'd5;

endpackage : ihex_pkg
`default_nettype wire

// File: rtl/ihex_nibble.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ihex_nibble                                               |
// | Purpose  : ASCII hex digit to 4-bit value decoder with valid flag    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ihex_nibble (
  input  logic [7:0] i_char,
  output logic [3:0] o_nib,
  output logic       o_valid
);

  // Accept 0-9, A-F, a-f; anything else reports invalid
  always_comb begin
    o_nib   = 4'h0;
    o_valid = 1'b0;
    if (i_char >= 8'h30 && i_char <= 8'h39) begin
      o_nib   = 4'(i_char - 8'h30);
      o_valid = 1'b1;
    end else if (i_char >= 8'h41 && i_char <= 8'h46) begin
      o_nib   = 4'(i_char - 8'h37);
      o_valid = 1'b1;
    end else if (i_char >= 8'h61 && i_char <= 8'h66) begin
      o_nib   = 4'(i_char - 8'h57);
      o_valid = 1'b1;
    end
  end

endmodule : ihex_nibble
`default_nettype wire

// File: rtl/ihex_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ihex_loader                                               |
// | Purpose  : Streaming Intel HEX parser driving byte-lane RAM writes   |
// |            from the ioctl download path.                             |
// | Options  : IHEX_CKSUM_EN - enable record checksum verification       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ihex_loader
  import ihex_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int BYTES     = 2,
  parameter int HEX_INDEX = 1
) (
  input  logic                              clk_sys,
  input  logic                              reset,
  input  logic                              ioctl_download,
  input  logic [7:0]                        ioctl_index,
  input  logic                              ioctl_wr,
  input  logic [7:0]                        ioctl_dout,
  output logic                              mem_we,
  output logic [ADDR_W-$clog2(BYTES)-1:0]   mem_addr,
  output logic [BYTES-1:0]                  mem_be,
  output logic [8*BYTES-1:0]                mem_data,
  output logic                              busy,
  output logic                              done,
  output logic [2:0]                        err
);

  localparam int LW = $clog2(BYTES);
  localparam int AW = ADDR_W - LW;

  state_t       r_state;
  state_t       w_state_nxt;

  logic         r_act_q;
  logic         r_busy;
  logic         r_done;
  logic [2:0]   r_err;
  logic [3:0]   r_nib_hi;
  logic [7:0]   r_count;
  logic [15:0]  r_offset;
  logic [1:0]   r_adr_cnt;
  logic [7:0]   r_type;
  logic [7:0]   r_idx;
  logic [7:0]   r_cksum;
  logic [15:0]  r_val;
  logic [31:0]  r_base;

  logic         r_we;
  logic [AW-1:0]      r_addr;
  logic [BYTES-1:0]   r_be;
  logic [8*BYTES-1:0] r_data;

  logic         w_act;
  logic         w_start;
  logic         w_fall;
  logic         w_strb;
  logic [3:0]   w_nib;
  logic         w_nib_ok;
  logic [7:0]   w_byte;
  logic [7:0]   w_sum;
  logic         w_ck_ok;
  logic [31:0]  w_eff;
  logic         w_in_range;
  logic [AW-1:0]      w_waddr;
  logic [BYTES-1:0]   w_wbe;

  logic         w_wr_req;
  logic         w_err_req;
  logic [2:0]   w_err_code;
  logic         w_done_set;
  logic         w_base_ld;

  ihex_nibble u_nib (
    .i_char  (ioctl_dout),
    .o_nib   (w_nib),
    .o_valid (w_nib_ok)
  );

  assign w_act   = ioctl_download && (ioctl_index == 8'(HEX_INDEX));
  assign w_start = w_act && !r_act_q;
  assign w_fall  = !w_act && r_act_q && r_busy;
  assign w_strb  = w_act && r_act_q && r_busy && ioctl_wr;

  assign w_byte     = {r_nib_hi, w_nib};
  assign w_sum      = r_cksum + w_byte;
  assign w_eff      = r_base + {16'h0000, r_offset} + {24'h000000, r_idx};
  assign w_in_range = ((w_eff >> ADDR_W) == 32'h0);

`ifdef IHEX_CKSUM_EN
  assign w_ck_ok = (w_sum == 8'h00);
`else
  assign w_ck_ok = 1'b1;
`endif

  generate
    if (LW > 0) begin : g_multi_lane
      assign w_waddr = w_eff[ADDR_W-1:LW];
      assign w_wbe   = BYTES'(1) << w_eff[LW-1:0];
    end else begin : g_single_lane
      assign w_waddr = w_eff[ADDR_W-1:0];
      assign w_wbe   = 1'b1;
    end
  endgenerate

  // Parser state register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode plus write/error/status requests for the datapath
  always_comb begin
    w_state_nxt = r_state;
    w_wr_req    = 1'b0;
    w_err_req   = 1'b0;
    w_err_code  = ERR_NONE;
    w_done_set  = 1'b0;
    w_base_ld   = 1'b0;
    if (w_start || w_fall) begin
      w_state_nxt = S_IDLE;
    end else if (w_strb) begin
      if (r_state != S_IDLE && r_state != S_DONE && r_state != S_ERR && !w_nib_ok) begin
        w_state_nxt = S_ERR;
        w_err_req   = 1'b1;
        w_err_code  = ERR_CHAR;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (ioctl_dout == 8'h3A) begin
              w_state_nxt = S_CNT_H;
            end else if (ioctl_dout != 8'h0D && ioctl_dout != 8'h0A &&
                         ioctl_dout != 8'h20 && ioctl_dout != 8'h09) begin
              w_state_nxt = S_ERR;
              w_err_req   = 1'b1;
              w_err_code  = ERR_CHAR;
            end
          end
          S_CNT_H: w_state_nxt = S_CNT_L;
          S_CNT_L: w_state_nxt = S_ADR;
          S_ADR:   if (r_adr_cnt == 2'd3) w_state_nxt = S_TYP_H;
          S_TYP_H: w_state_nxt = S_TYP_L;
          S_TYP_L: begin
            if (w_byte > REC_SLA ||
                ((w_byte == REC_ESA || w_byte == REC_ELA) && r_count != 8'd2)) begin
              w_state_nxt = S_ERR;
              w_err_req   = 1'b1;
              w_err_code  = ERR_TYPE;
            end else if (r_count == 8'd0) begin
              w_state_nxt = S_CK_H;
            end else begin
              w_state_nxt = S_DAT_H;
            end
          end
          S_DAT_H: w_state_nxt = S_DAT_L;
          S_DAT_L: begin
            if (r_type == REC_DATA) begin
              if (w_in_range) begin
                w_wr_req = 1'b1;
              end else begin
                w_err_req  = 1'b1;
                w_err_code = ERR_RANGE;
              end
            end
            w_state_nxt = ((r_idx + 8'd1) == r_count) ? S_CK_H : S_DAT_H;
          end
          S_CK_H: w_state_nxt = S_CK_L;
          S_CK_L: begin
            w_state_nxt = S_IDLE;
            if (!w_ck_ok) begin
              w_err_req  = 1'b1;
              w_err_code = ERR_CKSUM;
            end else if (r_type == REC_EOF) begin
              w_state_nxt = S_DONE;
              w_done_set  = 1'b1;
            end else if (r_type == REC_ESA || r_type == REC_ELA) begin
              w_base_ld = 1'b1;
            end
          end
          default: w_state_nxt = r_state;
        endcase
      end
    end
  end

  // Field capture, checksum accumulation and base address tracking
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_nib_hi  <= 4'h0;
      r_count   <= 8'h00;
      r_offset  <= 16'h0000;
      r_adr_cnt <= 2'd0;
      r_type    <= 8'h00;
      r_idx     <= 8'h00;
      r_cksum   <= 8'h00;
      r_val     <= 16'h0000;
      r_base    <= 32'h0;
    end else if (w_start) begin
      r_base  <= 32'h0;
      r_cksum <= 8'h00;
    end else if (w_strb && (w_nib_ok || r_state == S_IDLE)) begin
      case (r_state)
        S_IDLE:  begin
          r_cksum   <= 8'h00;
          r_adr_cnt <= 2'd0;
        end
        S_CNT_H, S_TYP_H, S_DAT_H, S_CK_H: r_nib_hi <= w_nib;
        S_CNT_L: begin
          r_count <= w_byte;
          r_cksum <= w_sum;
        end
        S_ADR: begin
          r_offset  <= {r_offset[11:0], w_nib};
          r_adr_cnt <= r_adr_cnt + 2'd1;
          if (r_adr_cnt[0]) r_cksum <= w_sum;
          else              r_nib_hi <= w_nib;
        end
        S_TYP_L: begin
          r_type  <= w_byte;
          r_cksum <= w_sum;
          r_idx   <= 8'h00;
          r_val   <= 16'h0000;
        end
        S_DAT_L: begin
          r_cksum <= w_sum;
          r_idx   <= r_idx + 8'd1;
          r_val   <= {r_val[7:0], w_byte};
        end
        S_CK_L: begin
          r_cksum <= w_sum;
          if (w_base_ld) begin
            r_base <= (r_type == REC_ESA) ? {12'h000, r_val, 4'h0} : {r_val, 16'h0000};
          end
        end
        default: r_cksum <= r_cksum;
      endcase
    end
  end

  // Download window tracking and sticky status flags
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_act_q <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= ERR_NONE;
    end else begin
      r_act_q <= w_act;
      if (w_start) begin
        r_busy <= 1'b1;
        r_done <= 1'b0;
        r_err  <= ERR_NONE;
      end else if (w_fall) begin
        r_busy <= 1'b0;
        if (!r_done && r_err == ERR_NONE) r_err <= ERR_TRUNC;
      end else begin
        if (w_done_set) r_done <= 1'b1;
        if (w_err_req && r_err == ERR_NONE) r_err <= w_err_code;
      end
    end
  end

  // Memory write port: one-cycle strobe with the byte replicated across lanes
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_be   <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_wr_req;
      if (w_wr_req) begin
        r_addr <= w_waddr;
        r_be   <= w_wbe;
        r_data <= {BYTES{w_byte}};
      end
    end
  end

  assign mem_we   = r_we;
  assign mem_addr = r_addr;
  assign mem_be   = r_be;
  assign mem_data = r_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule : ihex_loader
`default_nettype wire

// File: tb/tb_ihex_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ihex_loader                                            |
// | Purpose  : Directed self-checking bench for ihex_loader              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_ihex_loader;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index    = 8'd1;
  logic        ioctl_wr       = 1'b0;
  logic [7:0]  ioctl_dout     = 8'h00;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_data;
  logic        busy;
  logic        done;
  logic [2:0]  err;

  int n_cmp = 0;
  int n_bad = 0;

  // Write capture log, filled on the falling edge
  int          nwr = 0;
  logic [13:0] wa [0:63];
  logic [1:0]  wb [0:63];
  logic [15:0] wd [0:63];
  int          base_wr;

  ihex_loader #(.ADDR_W(15), .BYTES(2), .HEX_INDEX(1)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_be         (mem_be),
    .mem_data       (mem_data),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk_sys = ~clk_sys;

  // Record every write strobe seen by the memory port
  always @(negedge clk_sys) begin
    if (mem_we === 1'b1) begin
      wa[nwr % 64] <= mem_addr;
      wb[nwr % 64] <= mem_be;
      wd[nwr % 64] <= mem_data;
      nwr <= nwr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_sys);
  endtask

  // Back-to-back strobes, one character per cycle
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk_sys);
      ioctl_wr   = 1'b1;
      ioctl_dout = s.getc(i);
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl();
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    idle(2);
    base_wr = nwr;
  endtask

  task automatic end_dl();
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    idle(2);
  endtask

  task automatic chk_wr(input string tag, input int k, input logic [13:0] a,
                        input logic [1:0] b, input logic [15:0] d);
    chk({tag, "_addr"}, 32'(wa[(base_wr + k) % 64]), 32'(a));
    chk({tag, "_be"},   32'(wb[(base_wr + k) % 64]), 32'(b));
    chk({tag, "_data"}, 32'(wd[(base_wr + k) % 64]), 32'(d));
  endtask

  initial begin
    // Reset state
    idle(3);
    chk("rst_status", {28'h0, busy, done, err[1:0]}, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    @(negedge clk_sys);
    reset = 1'b0;
    idle(2);

    // 1: four byte writes, then EOF
    start_dl();
    chk("t1_busy", 32'(busy), 32'h1);
    send_str(":0400000001020304F2\r\n:00000001FF");
    idle(3);
    chk("t1_nwr", 32'(nwr - base_wr), 32'd4);
    chk_wr("t1_w0", 0, 14'h0000, 2'b01, 16'h0101);
    chk_wr("t1_w1", 1, 14'h0000, 2'b10, 16'h0202);
    chk_wr("t1_w2", 2, 14'h0001, 2'b01, 16'h0303);
    chk_wr("t1_w3", 3, 14'h0001, 2'b10, 16'h0404);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_err", 32'(err), 32'h0);
    end_dl();
    chk("t1_busy_off", 32'(busy), 32'h0);
    chk("t1_err_end", 32'(err), 32'h0);

    // 2: linear base pushes the write out of range
    start_dl();
    chk("t2_done_clr", 32'(done), 32'h0);
    send_str(":020000040001F9\r\n:0100000055AA\r\n");
    idle(3);
    chk("t2_nwr", 32'(nwr - base_wr), 32'd0);
    chk("t2_err", 32'(err), 32'h3);
    chk("t2_done0", 32'(done), 32'h0);
    send_str(":00000001FF");
    idle(2);
    chk("t2_done1", 32'(done), 32'h1);
    chk("t2_err_keep", 32'(err), 32'h3);
    end_dl();

    // 3: bad checksum still writes all data
    start_dl();
    chk("t3_err_clr", 32'(err), 32'h0);
    send_str(":0400000001020304F3");
    idle(3);
    chk("t3_nwr", 32'(nwr - base_wr), 32'd4);
    chk_wr("t3_w3", 3, 14'h0001, 2'b10, 16'h0404);
`ifdef IHEX_CKSUM_EN
    chk("t3_err", 32'(err), 32'h2);
`else
    chk("t3_err", 32'(err), 32'h0);
`endif
    end_dl();

    // 4: bad character, then everything absorbed
    start_dl();
    send_str(":04001G");
    idle(2);
    chk("t4_err", 32'(err), 32'h1);
    send_str(":0100000077 88\r\n:00000001FF");
    idle(3);
    chk("t4_done", 32'(done), 32'h0);
    chk("t4_err_keep", 32'(err), 32'h1);
    chk("t4_nwr", 32'(nwr - base_wr), 32'd0);
    end_dl();
    start_dl();
    chk("t4_err_clr", 32'(err), 32'h0);
    send_str(":00000001ff");
    idle(2);
    chk("t4_done_new", 32'(done), 32'h1);
    end_dl();

    // 5: truncated download
    start_dl();
    send_str(":0400");
    end_dl();
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_err", 32'(err), 32'h5);
    start_dl();
    chk("t5_err_clr", 32'(err), 32'h0);
    chk("t5_busy_on", 32'(busy), 32'h1);

    // 6: lowercase segment record, whitespace, then reset mid-data
    send_str("\r\n:020000020010ec\r\n\t :01000500ab4f\r\n");
    idle(3);
    chk("t6_nwr", 32'(nwr - base_wr), 32'd1);
    chk_wr("t6_w0", 0, 14'h0082, 2'b10, 16'habab);
    chk("t6_err", 32'(err), 32'h0);
    send_str(":02000000a");
    @(negedge clk_sys);
    reset = 1'b1;
    #1;
    chk("t6_rst_ctrl", {28'h0, mem_we, busy, done, err[2]}, 32'h0);
    chk("t6_rst_err", 32'(err), 32'h0);
    chk("t6_rst_addr", 32'(mem_addr), 32'h0);
    chk("t6_rst_bedata", {14'h0, mem_be, mem_data}, 32'h0);
    idle(2);
    reset = 1'b0;
    base_wr = nwr;
    send_str("b55\r\n:0100000011ee");
    idle(4);
    chk("t6_no_wr", 32'(nwr - base_wr), 32'd0);
    chk("t6_busy_after", 32'(busy), 32'h0);
    end_dl();

    // Unsupported record type
    start_dl();
    send_str(":00000006FA");
    idle(2);
    chk("t7_err_type", 32'(err), 32'h4);
    end_dl();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ihex_loader
`default_nettype wire
